// File: rtl/control_step_sequencer_pkg.sv
// rtl/control_step_sequencer_pkg.sv - shared state encoding, defaults and width helper
package control_step_sequencer_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_NUM_STEPS = 6;
    localparam int DEF_WAIT_STEP = 1;
    localparam int DEF_PL_DEPTH  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_A,
        ST_LD_B,
        ST_EXEC,
        ST_DONE
    } state_t;

    // Never returns less than 1 so it can always size a vector.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/control_step_sequencer_preload_fifo.sv
// rtl/control_step_sequencer_preload_fifo.sv - preload request buffer holding register index and value
module preload_fifo
    import control_step_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = 4,
    parameter int DEPTH  = DEF_PL_DEPTH,
    localparam int CNT_W = clog2(DEPTH + 1),
    localparam int PTR_W = clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              clr,
    input  logic              push_tvalid,
    output logic              push_tready,
    input  logic [IDX_W-1:0]  push_reg,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [IDX_W-1:0]  head_reg,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [IDX_W-1:0]  reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_fire;
    logic              pop_fire;

    // Ready comes from the registered count only, so a pop never frees a slot in the same cycle.
    assign push_tready = (count != CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign push_fire   = push_tvalid && push_tready;
    assign pop_fire    = pop && !empty;
    assign head_reg    = reg_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];

    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop_fire)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            if (push_fire && !pop_fire)
                count <= count + CNT_W'(1);
            else if (!push_fire && pop_fire)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (push_fire) begin
            reg_mem[wr_ptr]  <= push_reg;
            data_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/control_step_sequencer.sv
// rtl/control_step_sequencer.sv - register preload and T-step execute sequencer with memory waits
module control_step_sequencer
    import control_step_sequencer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int WAIT_STEP = DEF_WAIT_STEP,
    parameter int PL_DEPTH  = DEF_PL_DEPTH,
    localparam int REG_W    = clog2(NUM_REGS),
    localparam int CNT_W    = clog2(PL_DEPTH + 1),
    localparam int STEP_W   = clog2(NUM_STEPS)
) (
    input  logic                 Clock,
    input  logic                 clr,
    input  logic                 pl_valid,
    output logic                 pl_ready,
    input  logic [REG_W-1:0]     pl_reg,
    input  logic [DATA_W-1:0]    pl_data,
    input  logic                 start,
    input  logic                 mem_ready,
    output logic [DATA_W-1:0]    Mdatain,
    output logic                 Read,
    output logic                 MDRin,
    output logic                 MDRout,
    output logic [NUM_REGS-1:0]  Rin,
    output logic [NUM_STEPS-1:0] step,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     pl_count
);

    state_t            state_q;
    state_t            state_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic              start_pend_q;
    logic [REG_W-1:0]  head_reg;
    logic [DATA_W-1:0] head_data;
    logic              fifo_empty;
    logic              pop;

    assign pop = (state_q == ST_LD_B);

    preload_fifo #(
        .DATA_W (DATA_W),
        .IDX_W  (REG_W),
        .DEPTH  (PL_DEPTH)
    ) u_preload_fifo (
        .Clock       (Clock),
        .clr         (clr),
        .push_tvalid (pl_valid),
        .push_tready (pl_ready),
        .push_reg    (pl_reg),
        .push_data   (pl_data),
        .pop         (pop),
        .head_reg    (head_reg),
        .head_data   (head_data),
        .empty       (fifo_empty),
        .count       (pl_count)
    );

    // A start that cannot be served right away (busy, or preloads queued) is remembered.
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            start_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (state_d == ST_EXEC && state_q != ST_EXEC)
                start_pend_q <= 1'b0;
            else if (start && !(state_q == ST_IDLE && fifo_empty))
                start_pend_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        Mdatain = '0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        Rin     = '0;
        step    = '0;
        busy    = (state_q != ST_IDLE);
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LD_A;
                end else if (start || start_pend_q) begin
                    state_d = ST_EXEC;
                    step_d  = '0;
                end
            end
            ST_LD_A: begin
                Mdatain = head_data;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready)
                    state_d = ST_LD_B;
            end
            ST_LD_B: begin
                MDRout  = 1'b1;
                Rin     = NUM_REGS'(1) << head_reg;
                state_d = (pl_count > CNT_W'(1)) ? ST_LD_A : ST_IDLE;
            end
            ST_EXEC: begin
                step = NUM_STEPS'(1) << step_q;
                if (step_q == STEP_W'(WAIT_STEP))
                    Read = 1'b1;
                if (step_q == STEP_W'(WAIT_STEP) && !mem_ready) begin
                    state_d = ST_EXEC;
                end else if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                    state_d = ST_DONE;
                    step_d  = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
